// File: rtl/des_key_sched_seq_if.sv
// DES round-key sequencer bus: start/key request
// and the valid/ready round-key stream.
interface des_key_sched_seq_if;
    logic        i_start;
    logic        i_decrypt;
    logic [55:0] i_key;
    logic        i_abort;
    logic        i_ready;
    logic [55:0] o_round_key;
    logic [3:0]  o_round;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_start,
        output i_decrypt,
        output i_key,
        output i_abort,
        output i_ready,
        input  o_round_key,
        input  o_round,
        input  o_valid,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_decrypt,
        input  i_key,
        input  i_abort,
        input  i_ready,
        output o_round_key,
        output o_round,
        output o_valid,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/des_key_sched_seq.sv
// Sequential DES round-key sequencer: emits the 16
// rotated C||D keys (pre-PC-2), one per handshake.
module des_key_sched_seq (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    des_key_sched_seq_if.slave   bus
);
    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic        dec_q, dec_d;
    logic [55:0] key_q, key_d;
    logic [3:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nxt_round;
    logic        two;

    // Rotate both 28-bit halves left by 1 or 2.
    function automatic logic [55:0] rotl(
        input logic [55:0] k,
        input logic        by2
    );
        logic [27:0] c;
        logic [27:0] d;
        c = k[55:28];
        d = k[27:0];
        if (by2)
            return {c[25:0], c[27:26], d[25:0], d[27:26]};
        return {c[26:0], c[27], d[26:0], d[27]};
    endfunction

    // Rotate both 28-bit halves right by 1 or 2.
    function automatic logic [55:0] rotr(
        input logic [55:0] k,
        input logic        by2
    );
        logic [27:0] c;
        logic [27:0] d;
        c = k[55:28];
        d = k[27:0];
        if (by2)
            return {c[1:0], c[27:2], d[1:0], d[27:2]};
        return {c[0], c[27:1], d[0], d[27:1]};
    endfunction

    // Amount for the next round; rounds 1, 8, 15 step
    // by one in both directions, all others by two.
    always_comb begin
        nxt_round = round_q + 4'd1;
        two = !((nxt_round == 4'd1) ||
                (nxt_round == 4'd8) ||
                (nxt_round == 4'd15));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    dec_d   = bus.i_decrypt;
                    key_d   = bus.i_decrypt ? bus.i_key
                                            : rotl(bus.i_key, 1'b0);
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.i_abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    round_d = 4'd0;
                end else if (valid_q && bus.i_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = nxt_round;
                        key_d   = dec_q ? rotr(key_q, two)
                                        : rotl(key_q, two);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            dec_q   <= 1'b0;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_round_key = key_q;
    assign bus.o_round     = round_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// Testbench for des_key_sched_seq: directed and
// random schedules against a cumulative-shift model.
module tb_des_key_sched_seq;
    logic clk;
    logic rst_n;

    des_key_sched_seq_if bus ();

    des_key_sched_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int cyc;

    logic [55:0] exp_k [16];
    logic [55:0] obs_k [16];
    logic [55:0] enc_obs [16];

    int enc_amt [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_amt [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] rl28(
        input logic [27:0] x,
        input int          n
    );
        logic [55:0] w;
        w = {x, x} >> (28 - n);
        return w[27:0];
    endfunction

    function automatic logic [27:0] rr28(
        input logic [27:0] x,
        input int          n
    );
        logic [55:0] w;
        w = {x, x} >> n;
        return w[27:0];
    endfunction

    // Round r = key halves rotated by cumulative amount 0..r.
    task automatic model(input logic [55:0] key, input logic dec);
        int sum;
        sum = 0;
        for (int r = 0; r < 16; r++) begin
            sum += dec ? dec_amt[r] : enc_amt[r];
            if (dec)
                exp_k[r] = {rr28(key[55:28], sum), rr28(key[27:0], sum)};
            else
                exp_k[r] = {rl28(key[55:28], sum), rl28(key[27:0], sum)};
        end
    endtask

    task automatic run_sched(
        input logic [55:0] key,
        input logic        dec,
        input int          stall_at,
        input int          abort_at,
        input int          inj_at,
        input bit          b2b,
        input logic [55:0] key2,
        input logic        dec2
    );
        model(key, dec);
        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_key     = key;
        bus.i_decrypt = dec;
        bus.i_ready   = 1'b1;
        cyc = 0;
        @(negedge clk);
        cyc++;
        bus.i_start   = 1'b0;
        bus.i_key     = {$urandom, $urandom};
        bus.i_decrypt = ~dec;
        for (int r = 0; r < 16; r++) begin
            if (r == stall_at) begin
                bus.i_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("stall_valid", 64'(bus.o_valid), 64'd1);
                    chk("stall_round", 64'(bus.o_round), 64'(r));
                    chk("stall_key", 64'(bus.o_round_key), 64'(exp_k[r]));
                    @(negedge clk);
                    cyc++;
                end
                bus.i_ready = 1'b1;
            end
            chk("valid", 64'(bus.o_valid), 64'd1);
            chk("round", 64'(bus.o_round), 64'(r));
            chk("key", 64'(bus.o_round_key), 64'(exp_k[r]));
            chk("busy", 64'(bus.o_busy), 64'd1);
            chk("done_early", 64'(bus.o_done), 64'd0);
            obs_k[r] = bus.o_round_key;
            if (r == abort_at) begin
                bus.i_abort = 1'b1;
                @(negedge clk);
                bus.i_abort = 1'b0;
                chk("abort_valid", 64'(bus.o_valid), 64'd0);
                chk("abort_busy", 64'(bus.o_busy), 64'd0);
                chk("abort_done", 64'(bus.o_done), 64'd0);
                chk("abort_round", 64'(bus.o_round), 64'd0);
                @(negedge clk);
                chk("abort_done2", 64'(bus.o_done), 64'd0);
                chk("abort_valid2", 64'(bus.o_valid), 64'd0);
                return;
            end
            if (r == inj_at) begin
                bus.i_start   = 1'b1;
                bus.i_key     = ~key;
                bus.i_decrypt = ~dec;
            end
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
        end
        chk("done", 64'(bus.o_done), 64'd1);
        chk("done_lat", 64'(cyc), 64'(stall_at >= 0 ? 22 : 17));
        chk("end_valid", 64'(bus.o_valid), 64'd0);
        chk("end_busy", 64'(bus.o_busy), 64'd0);
        chk("end_round", 64'(bus.o_round), 64'd15);
        chk("end_key", 64'(bus.o_round_key), 64'(exp_k[15]));
        if (b2b) begin
            bus.i_start   = 1'b1;
            bus.i_key     = key2;
            bus.i_decrypt = dec2;
            model(key2, dec2);
            @(negedge clk);
            bus.i_start = 1'b0;
            chk("b2b_valid", 64'(bus.o_valid), 64'd1);
            chk("b2b_round", 64'(bus.o_round), 64'd0);
            chk("b2b_key", 64'(bus.o_round_key), 64'(exp_k[0]));
            chk("b2b_done", 64'(bus.o_done), 64'd0);
        end else begin
            @(negedge clk);
            chk("done_clr", 64'(bus.o_done), 64'd0);
            chk("idle_busy", 64'(bus.o_busy), 64'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_key"}, 64'(bus.o_round_key), 64'd0);
        chk({tag, "_round"}, 64'(bus.o_round), 64'd0);
        chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] k;
        logic [55:0] rk;
        logic        rd;
        n_chk  = 0;
        n_fail = 0;
        k = 56'h00000010000001;
        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_decrypt = 1'b0;
        bus.i_key     = '0;
        bus.i_abort   = 1'b0;
        bus.i_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        run_sched(k, 1'b0, -1, -1, -1, 1'b0, '0, 1'b0);
        chk("enc_r0", 64'(obs_k[0]), 64'h00000020000002);
        chk("enc_r1", 64'(obs_k[1]), 64'h00000040000004);
        chk("enc_r2", 64'(obs_k[2]), 64'h00000100000010);
        chk("enc_r15", 64'(obs_k[15]), 64'h00000010000001);
        enc_obs = obs_k;

        run_sched(k, 1'b1, -1, -1, -1, 1'b0, '0, 1'b0);
        chk("dec_r0", 64'(obs_k[0]), 64'h00000010000001);
        chk("dec_r1", 64'(obs_k[1]), 64'h80000008000000);
        chk("dec_r2", 64'(obs_k[2]), 64'h20000002000000);
        chk("dec_r15", 64'(obs_k[15]), 64'h00000020000002);
        for (int r = 0; r < 16; r++)
            chk("dec_vs_enc", 64'(obs_k[r]), 64'(enc_obs[15 - r]));

        run_sched(k, 1'b0, 7, -1, -1, 1'b0, '0, 1'b0);
        run_sched(k, 1'b0, -1, 9, -1, 1'b0, '0, 1'b0);
        run_sched(k, 1'b0, -1, -1, -1, 1'b0, '0, 1'b0);
        run_sched(k, 1'b1, -1, -1, 5, 1'b0, '0, 1'b0);

        // start with abort in IDLE is ignored
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        bus.i_key   = k;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        chk("sa_valid", 64'(bus.o_valid), 64'd0);
        chk("sa_busy", 64'(bus.o_busy), 64'd0);

        rk = 56'h0123456789abcd;
        run_sched(k, 1'b0, -1, -1, -1, 1'b1, rk, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("arst");
        @(negedge clk);
        chk_zero("arst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_nodone", 64'(bus.o_done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            rk = {$urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            run_sched(rk, 1'b0,
                      (i % 3 == 0) ? int'($urandom_range(0, 15)) : -1,
                      -1, -1, 1'b0, '0, 1'b0);
            enc_obs = obs_k;
            run_sched(rk, 1'b1, -1, -1,
                      rd ? int'($urandom_range(0, 14)) : -1,
                      1'b0, '0, 1'b0);
            for (int r = 0; r < 16; r++)
                chk("rnd_dec_vs_enc", 64'(obs_k[r]), 64'(enc_obs[15 - r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential DES round-key sequencer. It emits the 16 rotated C||D keys (pre-PC-2) one per handshake, for encryption (left rotations) or decryption (right rotations).
- It sits between the PC-1 stage and the PC-2/round datapath. The round engine pulls subkeys one per round instead of using a 16-way combinational shift tree.
- Decrypt mode is the reverse direction of the encrypt key schedule: the same subkeys, produced in order K16..K1.

Parameters:
- None. Key width (56), half width (28) and round count (16) are fixed by DES.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle request to begin a schedule; sampled only in IDLE
- i_decrypt  input  1  0 = encrypt (left rotate), 1 = decrypt (right rotate); sampled with i_start
- i_key  input  56  PC-1 output; C = [55:28], D = [27:0]; sampled with i_start
- i_abort  input  1  synchronous abort; returns to IDLE next cycle
- i_ready  input  1  consumer accepts o_round_key when high with o_valid
- o_round_key  output  56  rotated C||D for the current round
- o_round  output  4  round index 0..15 of o_round_key
- o_valid  output  1  o_round_key/o_round are valid
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse after round 15 is accepted

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_round_key=0, o_round=0, o_valid=0, o_busy=0, o_done=0; latched mode cleared.
- Shift schedule, indexed by round 0..15:
  - Encrypt left amounts: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt right amounts: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C and D rotate independently within their 28 bits; no bits cross between halves.
- Encrypt round r key = i_key with each half rotated left by the cumulative sum of amounts 0..r. Round 15 equals i_key (total 28).
- Decrypt round r key = encrypt round (15-r) key. Round 0 equals i_key; round 15 equals encrypt round 0.
- States: IDLE, ACTIVE.
- IDLE:
  - On i_start=1 with i_abort=0: latch i_decrypt.
  - Load o_round_key with the round-0 rotation of i_key (rotl1 in encrypt, unrotated in decrypt).
  - Set o_round=0, o_valid=1, o_busy=1; go to ACTIVE.
  - Latency: first key is valid the cycle after i_start.
  - i_start with i_abort=1 is ignored.
- ACTIVE, transfer (o_valid & i_ready):
  - If o_round<15: o_round increments and o_round_key is rotated by the next scheduled amount, on the same edge. o_valid stays 1, so one key per cycle under continuous i_ready.
  - If o_round==15: o_valid=0, o_busy=0, o_done=1 for exactly one cycle; go to IDLE. o_round_key and o_round hold their last values.
- ACTIVE, stall (i_ready=0): o_round_key, o_round and o_valid hold; no rotation occurs.
- i_start, i_decrypt and i_key are ignored while busy. There is no restart mid-schedule; i_start must wait for o_busy=0.
- i_abort=1:
  - In ACTIVE, it overrides any transfer in that cycle: next state IDLE, o_valid=0, o_busy=0, no o_done, o_round=0.
  - In IDLE it has no effect.
- o_round never wraps from 15 to 0 inside a schedule.
- i_start in the same cycle as o_done is high: accepted, since the state is IDLE that cycle.
- Reset asserted mid-schedule: immediate return to the reset values; no o_done.

Test Plan:
- Encrypt, i_key=56'h00000010000001, i_ready=1 continuously:
  - r0..r2 = 56'h00000020000002, 56'h00000040000004, 56'h00000100000010.
  - r15 = 56'h00000010000001.
  - o_done pulses 17 cycles after i_start.
- Decrypt, same key:
  - r0 = 56'h00000010000001, r1 = 56'h80000008000000, r2 = 56'h20000002000000.
  - r15 = 56'h00000020000002.
- Random keys, both modes: decrypt round r equals encrypt round 15-r for all r; compare against a software DES key schedule.
- Backpressure: hold i_ready=0 for 5 cycles at round 7 -> key and o_round stable and o_valid=1 throughout; the sequence resumes unchanged.
- i_abort at round 9 with i_ready=1 -> IDLE next cycle, o_valid=0, no o_done. A new i_start then restarts at round 0.
- i_start while ACTIVE is ignored. i_rst_n low mid-schedule -> all outputs 0 asynchronously. Back-to-back i_start on the o_done cycle begins a new schedule.
